dual_accumulator: RTL and testbench
===================================

Name: dual_accumulator

Overview:
- Clocked accumulator block with two independent lanes sharing one clock, reset and enable.
- Binary lane: adds a W-bit input into a W-bit register, wrapping modulo 2^W.
- Modulo lane: adds a small input into a register that always holds a value in [0, M-1].
- Used for running sums, and for phase or index counters that must wrap at a non-power-of-two modulus.

Parameters:
- W, 16, width of the binary lane (d, acc); W >= 1.
- M, 50, modulus of the modulo lane; M >= 2.
- MW, $clog2(M) (=6 for M=50), width of dm/accm; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  accumulate enable for both lanes.
- d  input  W  binary-lane addend, unsigned.
- acc  output  W  binary-lane accumulator, registered.
- dm  input  MW  modulo-lane addend, unsigned; any value 0..2^MW-1 is legal, including values >= M.
- accm  output  MW  modulo-lane accumulator, registered; always < M.

Behaviour:
- Single clock domain; all state updates on rising clk; no combinational input-to-output path.
- Reset:
  - rst=1 at an edge -> acc=0 and accm=0 after that edge.
  - rst overrides en.
  - Reset mid-accumulation discards the running sum.
  - Outputs are undefined before the first reset edge.
- Binary lane:
  - en=1 -> acc <= (acc + d) mod 2^W; carry out is discarded, no overflow flag.
  - en=0 -> acc holds.
- Modulo lane:
  - en=1 -> accm <= (accm + dm) mod M.
  - en=0 -> accm holds.
- Modulo arithmetic:
  - Form s = accm + dm in MW+2 bits. Max is (M-1) + (2^MW - 1) <= 3M-3.
  - If s >= 2M, result = s - 2M; else if s >= M, result = s - M; else result = s.
  - Implement with compare/subtract only; no divider.
- Latency: one cycle. The input sampled at edge k is reflected in the output after edge k.
- Invariant: accm < M at all times after reset.
- Cross-lane property: with dm = d mod 2^MW, the same en, and no wrap of either lane, accm == acc mod M holds every cycle. Once acc wraps at 2^W, or d exceeds 2^MW-1, the lanes are independent and the property no longer applies.
- Power-of-two M: the correction logic must still yield (accm + dm) mod M.

Test Plan:
- Reset and ramp: hold rst=1 for 3 edges -> acc=0, accm=0. Release with en=1 and d=dm=1,2,3,... on successive edges -> after 10 edges acc=55, accm=5; after 20 edges acc=210, accm=10. Check accm == acc%50 each cycle.
- Enable gating: acc=100, accm=7, en=0 for 5 edges with d=9, dm=9 -> both hold. Re-assert en=1 with d=dm=9 -> acc=109, accm=16 after one edge.
- Binary wrap: acc=65530, d=10, en=1 -> acc=4.
- Modulo boundaries, each row from a fresh load:
  - accm=49, dm=1 -> 0
  - accm=49, dm=63 -> 12 (s=112, second subtraction)
  - accm=0, dm=50 -> 0
  - accm=0, dm=49 -> 49
  - accm=37, dm=13 -> 0
- Reset priority: mid-ramp, assert rst=1 with en=1 and d=dm=5 for one edge -> acc=0, accm=0. Next edge with rst=0 -> acc=5, accm=5.
- Randomised: 10,000 cycles of random en/d/dm against a reference model; accm < 50 always, and both lanes match the model exactly.

Source files
------------

// File: rtl/dual_accumulator.sv
// -----------------------------------------------------------------------------
// dual_accumulator
//   Two independent accumulator lanes that share one clock, reset and enable.
//   - Binary lane: acc <= (acc + d) mod 2^W. The carry out is dropped.
//   - Modulo lane: accm <= (accm + dm) mod M. accm always stays in [0, M-1].
//   Both outputs are registered and have one cycle of latency. There is no
//   combinational path from any input to any output.
//
// Parameters
//   W   width of the binary lane (W >= 1)
//   M   modulus of the modulo lane (M >= 2)
//   MW  width of dm/accm, derived as $clog2(M); it cannot be overridden
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   synchronous reset, active-high; takes priority over en
//   en    in   1   accumulate enable for both lanes
//   d     in   W   binary-lane addend, unsigned
//   acc   out  W   binary-lane accumulator
//   dm    in   MW  modulo-lane addend; any value 0..2^MW-1 is legal
//   accm  out  MW  modulo-lane accumulator, always < M
// -----------------------------------------------------------------------------
module dual_accumulator #(
    parameter  int W  = 16,
    parameter  int M  = 50,
    localparam int MW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  acc,
    input  logic [MW-1:0] dm,
    output logic [MW-1:0] accm
);

    // The sum accm + dm is at most (M-1) + (2^MW-1), which is <= 3M-3.
    // MW+2 bits are enough to hold both the sum and the constant 2M.
    localparam logic [MW+1:0] M_1X = (MW+2)'(M);
    localparam logic [MW+1:0] M_2X = (MW+2)'(2 * M);

    logic [MW+1:0] sum_wide;
    logic [MW-1:0] sub_amt;
    logic [MW-1:0] accm_next;

    assign sum_wide = {2'b00, accm} + {2'b00, dm};

    // Pick how much to subtract: 0, M or 2M. This uses compare and subtract
    // only, with no divider. The subtraction runs in MW bits. The true result
    // is always below M <= 2^MW, so arithmetic modulo 2^MW gives the exact
    // value. That also covers a power-of-two M, where the truncated constant
    // becomes 0.
    always_comb begin
        sub_amt = '0;
        if (sum_wide >= M_2X)
            sub_amt = MW'(2 * M);
        else if (sum_wide >= M_1X)
            sub_amt = MW'(M);
    end

    assign accm_next = accm + dm - sub_amt;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            accm <= '0;
        end else if (en) begin
            acc  <= acc + d;
            accm <= accm_next;
        end
    end

endmodule

// File: tb/tb_dual_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dual_accumulator
//   Scoreboard bench for dual_accumulator (W=16, M=50).
//   The stimulus process pushes the expected outputs for every edge it drives.
//   The monitor pops one entry 1 time unit after each rising edge and compares
//   it with the outputs. Directed points carry hand-computed constants. All
//   other edges use a small reference model based on the % operator.
// -----------------------------------------------------------------------------
module tb_dual_accumulator;

    localparam int W  = 16;
    localparam int M  = 50;
    localparam int MW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [W-1:0]  d   = '0;
    logic [MW-1:0] dm  = '0;
    logic [W-1:0]  acc;
    logic [MW-1:0] accm;

    dual_accumulator #(.W(W), .M(M)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .d    (d),
        .acc  (acc),
        .dm   (dm),
        .accm (accm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  acc;
        logic [MW-1:0] accm;
        int            tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [W-1:0] m_acc  = '0;
    int           m_accm = 0;
    int           step_no = 0;

    // Drive one edge. The model expectation is pushed unless hand values are
    // supplied. Hand values are hand-computed constants for the directed points.
    task automatic step(input logic r, input logic e, input logic [W-1:0] dd,
                        input logic [MW-1:0] ddm, input bit hand,
                        input int hacc, input int haccm);
        exp_t x;
        rst = r; en = e; d = dd; dm = ddm;
        if (r) begin
            m_acc  = '0;
            m_accm = 0;
        end else if (e) begin
            m_acc  = m_acc + dd;
            m_accm = (m_accm + int'(ddm)) % M;
        end
        step_no++;
        x.tag = step_no;
        if (hand) begin
            x.acc  = W'(hacc);
            x.accm = MW'(haccm);
        end else begin
            x.acc  = m_acc;
            x.accm = MW'(m_accm);
        end
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, '0, '0, 1'b1, 0, 0);
    endtask

    // Load the lanes from zero: reset, then one enabled edge.
    task automatic load(input int a, input int am);
        do_reset(1);
        step(1'b0, 1'b1, W'(a), MW'(am), 1'b1, a, am);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (acc !== x.acc) begin
                    errors++;
                    $display("FAIL acc step %0d: got %0d expected %0d", x.tag, acc, x.acc);
                end
                checks++;
                if (accm !== x.accm) begin
                    errors++;
                    $display("FAIL accm step %0d: got %0d expected %0d", x.tag, accm, x.accm);
                end
                checks++;
                if (!(accm < MW'(M))) begin
                    errors++;
                    $display("FAIL accm_range step %0d: got %0d required < %0d", x.tag, accm, M);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int wait_cnt;
        @(posedge clk);
        #2;

        // Reset, then a ramp of d = dm = 1, 2, 3, ...
        do_reset(3);
        for (int k = 1; k <= 20; k++) begin
            if (k == 10)      step(1'b0, 1'b1, W'(k), MW'(k), 1'b1, 55, 5);
            else if (k == 20) step(1'b0, 1'b1, W'(k), MW'(k), 1'b1, 210, 10);
            else              step(1'b0, 1'b1, W'(k), MW'(k), 1'b0, 0, 0);
        end

        // Enable gating
        load(100, 7);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'd9, 6'd9, 1'b1, 100, 7);
        step(1'b0, 1'b1, 16'd9, 6'd9, 1'b1, 109, 16);

        // Binary wrap
        load(65530, 0);
        step(1'b0, 1'b1, 16'd10, 6'd0, 1'b1, 4, 0);

        // Modulo boundaries, each starting from a fresh load
        load(0, 49); step(1'b0, 1'b1, '0, 6'd1,  1'b1, 0, 0);
        load(0, 49); step(1'b0, 1'b1, '0, 6'd63, 1'b1, 0, 12);
        load(0, 0);  step(1'b0, 1'b1, '0, 6'd50, 1'b1, 0, 0);
        load(0, 0);  step(1'b0, 1'b1, '0, 6'd49, 1'b1, 0, 49);
        load(0, 37); step(1'b0, 1'b1, '0, 6'd13, 1'b1, 0, 0);

        // Reset priority in the middle of a ramp
        do_reset(1);
        step(1'b0, 1'b1, 16'd1, 6'd1, 1'b1, 1, 1);
        step(1'b0, 1'b1, 16'd2, 6'd2, 1'b1, 3, 3);
        step(1'b0, 1'b1, 16'd3, 6'd3, 1'b1, 6, 6);
        step(1'b1, 1'b1, 16'd5, 6'd5, 1'b1, 0, 0);
        step(1'b0, 1'b1, 16'd5, 6'd5, 1'b1, 5, 5);

        // Randomised run against the model
        do_reset(1);
        for (int i = 0; i < 10000; i++)
            step(1'b0, 1'($urandom_range(0, 1)), W'($urandom), MW'($urandom_range(0, 63)),
                 1'b0, 0, 0);

        // Let the monitor drain the queue, with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
